memory_map: RTL

// - Nibble-wide data memory system downstream of regs. Decodes memory_addr into main RAM, display RAM and I/O.
// - Returns registered read data to regs.
// - Gives the LCD controller a second read port into display RAM.
// - Forwards I/O accesses to peripherals as single-cycle strobes.

---
 rtl/memory_map_pkg.sv | 61 ++++++
 rtl/memory_map_nibble_ram.sv | 49 ++++
 rtl/memory_map.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/memory_map_pkg.sv
// Shared types and address map for the nibble-wide data memory system.
// Holds the region enum, the I/O read-strobe FSM states, the window
// base/limit constants and the address-decode helpers used by memory_map.
package memory_map_pkg;

  localparam int RAM_WORDS  = 640;
  localparam int VRAM_WORDS = 160;
  localparam int VRAM_HALF  = 80;
  localparam int RAM_AW     = $clog2(RAM_WORDS);
  localparam int VRAM_AW    = $clog2(VRAM_WORDS);

  typedef logic [RAM_AW-1:0]  ram_idx_t;
  typedef logic [VRAM_AW-1:0] vram_idx_t;

  localparam logic [11:0] RAM_BASE      = 12'h000;
  localparam logic [11:0] RAM_LIMIT     = 12'(RAM_WORDS - 1);
  localparam logic [11:0] VRAM_LO_BASE  = 12'hE00;
  localparam logic [11:0] VRAM_LO_LIMIT = 12'hE4F;
  localparam logic [11:0] VRAM_HI_BASE  = 12'hE80;
  localparam logic [11:0] VRAM_HI_LIMIT = 12'hECF;
  localparam logic [11:0] IO_BASE       = 12'hF00;
  localparam logic [11:0] IO_LIMIT      = 12'hF7F;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_VRAM,
    REGION_IO,
    REGION_NONE
  } mem_region_t;

  typedef enum logic {
    IO_IDLE,
    IO_HELD
  } io_state_t;

  // Main RAM starts at address zero, so only its upper limit needs testing.
  function automatic mem_region_t decode_region(input logic [11:0] addr);
    mem_region_t r;
    r = REGION_NONE;
    if (addr <= RAM_LIMIT)
      r = REGION_RAM;
    else if ((addr >= VRAM_LO_BASE && addr <= VRAM_LO_LIMIT) ||
             (addr >= VRAM_HI_BASE && addr <= VRAM_HI_LIMIT))
      r = REGION_VRAM;
    else if (addr >= IO_BASE && addr <= IO_LIMIT)
      r = REGION_IO;
    return r;
  endfunction

  // The two 80-nibble display windows are packed back to back into one
  // 160-entry display RAM; the upper window starts at index 80.
  function automatic vram_idx_t vram_index(input logic [11:0] addr);
    vram_idx_t idx;
    if (addr <= VRAM_LO_LIMIT)
      idx = vram_idx_t'(addr - VRAM_LO_BASE);
    else
      idx = vram_idx_t'(addr - VRAM_HI_BASE + 12'(VRAM_HALF));
    return idx;
  endfunction

endpackage

// File: rtl/memory_map_nibble_ram.sv
// nibble_ram: DEPTH x 4-bit storage with one read/write port (a) and one
// independent read-only port (b). Both reads are registered and read-first.
// Ports:
//   clk, reset          clock and synchronous active-high reset (clears the
//                       read registers only, never the storage)
//   write_en, addr,
//   write_data          port a write
//   read_data           port a registered read data
//   addr_b, read_data_b port b index and registered read data
// Out-of-range indices read as 0 and never write.
module nibble_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          write_en,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    write_data,
  output logic [3:0]    read_data,
  input  logic [AW-1:0] addr_b,
  output logic [3:0]    read_data_b
);

  logic [3:0] mem [DEPTH];
  logic       addr_ok;
  logic       addr_b_ok;

  assign addr_ok   = 32'(addr) < DEPTH;
  assign addr_b_ok = 32'(addr_b) < DEPTH;

  // Storage has no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (write_en && addr_ok)
      mem[addr] <= write_data;
  end

  // Both read ports sample the old contents, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data   <= '0;
      read_data_b <= '0;
    end else begin
      read_data   <= addr_ok   ? mem[addr]   : 4'h0;
      read_data_b <= addr_b_ok ? mem[addr_b] : 4'h0;
    end
  end

endmodule

// File: rtl/memory_map.sv
// memory_map: decodes the 12-bit nibble address from regs into main RAM,
// display RAM and I/O, returns registered read data, gives the LCD a second
// read port into display RAM and forwards I/O accesses as 1-cycle strobes.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   memory_write_en/addr/
//   memory_write_data              CPU access from regs
//   memory_read_data               registered CPU read data
//   lcd_addr, lcd_data             display RAM read port (index 0..159)
//   io_addr, io_write_en,
//   io_read_en, io_write_data,
//   io_read_data                   peripheral bus
//   mem_busy                       high while the reset clear walk runs
// Optional feature: define MEMORY_MAP_RAM_CLEAR_EN to zero both RAMs after
// every reset; without it mem_busy is tied low and RAM powers up undefined.
module memory_map
  import memory_map_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_write_en,
  input  logic [11:0] memory_addr,
  input  logic [3:0]  memory_write_data,
  output logic [3:0]  memory_read_data,
  input  logic [7:0]  lcd_addr,
  output logic [3:0]  lcd_data,
  output logic [6:0]  io_addr,
  output logic        io_write_en,
  output logic        io_read_en,
  output logic [3:0]  io_write_data,
  input  logic [3:0]  io_read_data,
  output logic        mem_busy
);

  mem_region_t region;
  mem_region_t region_q;
  io_state_t   io_state;
  logic [11:0] held_addr;
  logic [3:0]  io_capture;
  logic        busy;
  logic        cpu_ok;
  logic        ram_we;
  logic        vram_we;
  ram_idx_t    ram_addr;
  vram_idx_t   vram_addr;
  logic [3:0]  ram_wd;
  logic [3:0]  vram_wd;
  logic [3:0]  ram_rd;
  logic [3:0]  vram_rd;
  logic [3:0]  unused_ram_b;

  assign region = decode_region(memory_addr);
  assign cpu_ok = !reset && !busy;

`ifdef MEMORY_MAP_RAM_CLEAR_EN
  localparam int CLEAR_CYCLES = 640;

  ram_idx_t clear_count;
  logic     clear_busy;

  // Clear walk: reset (re)starts the counter; it then steps once per cycle
  // and drops busy after the last address has been zeroed.
  always_ff @(posedge clk) begin
    if (reset) begin
      clear_busy  <= 1'b1;
      clear_count <= '0;
    end else if (clear_busy) begin
      if (clear_count == ram_idx_t'(CLEAR_CYCLES - 1))
        clear_busy <= 1'b0;
      else
        clear_count <= clear_count + 1'b1;
    end
  end

  assign busy = clear_busy;
`else
  assign busy = 1'b0;
`endif

  // Port a of each RAM normally follows the CPU; the clear walk takes it over.
  always_comb begin
    ram_we    = cpu_ok && memory_write_en && (region == REGION_RAM);
    ram_addr  = ram_idx_t'(memory_addr - RAM_BASE);
    ram_wd    = memory_write_data;
    vram_we   = cpu_ok && memory_write_en && (region == REGION_VRAM);
    vram_addr = vram_index(memory_addr);
    vram_wd   = memory_write_data;
`ifdef MEMORY_MAP_RAM_CLEAR_EN
    if (clear_busy) begin
      ram_we    = 1'b1;
      ram_addr  = clear_count;
      ram_wd    = 4'h0;
      vram_we   = 32'(clear_count) < VRAM_WORDS;
      vram_addr = vram_idx_t'(clear_count);
      vram_wd   = 4'h0;
    end
`endif
  end

  nibble_ram #(.DEPTH(RAM_WORDS), .AW(RAM_AW)) u_ram (
    .clk         (clk),
    .reset       (reset),
    .write_en    (ram_we),
    .addr        (ram_addr),
    .write_data  (ram_wd),
    .read_data   (ram_rd),
    .addr_b      ('0),
    .read_data_b (unused_ram_b)
  );

  nibble_ram #(.DEPTH(VRAM_WORDS), .AW(VRAM_AW)) u_vram (
    .clk         (clk),
    .reset       (reset),
    .write_en    (vram_we),
    .addr        (vram_addr),
    .write_data  (vram_wd),
    .read_data   (vram_rd),
    .addr_b      (lcd_addr),
    .read_data_b (lcd_data)
  );

  // A read strobe fires only from IO_IDLE, so a held address pulses once and
  // a new address passes through IO_IDLE before pulsing again.
  assign io_read_en    = cpu_ok && !memory_write_en && (region == REGION_IO) &&
                         (io_state == IO_IDLE);
  assign io_write_en   = cpu_ok && memory_write_en && (region == REGION_IO);
  assign io_addr       = memory_addr[6:0];
  assign io_write_data = memory_write_data;
  assign mem_busy      = busy;

  // I/O read FSM plus the registered region that steers the read mux; the
  // peripheral value is captured only on the strobe and held while IO_HELD.
  always_ff @(posedge clk) begin
    if (reset) begin
      io_state   <= IO_IDLE;
      held_addr  <= '0;
      io_capture <= '0;
      region_q   <= REGION_NONE;
    end else begin
      region_q <= cpu_ok ? region : REGION_NONE;
      unique case (io_state)
        IO_IDLE: begin
          if (io_read_en) begin
            io_state   <= IO_HELD;
            held_addr  <= memory_addr;
            io_capture <= io_read_data;
          end
        end
        IO_HELD: begin
          if (memory_addr != held_addr)
            io_state <= IO_IDLE;
        end
        default: io_state <= IO_IDLE;
      endcase
    end
  end

  // Unmapped accesses and clear-walk cycles read back as zero.
  always_comb begin
    memory_read_data = 4'h0;
    unique case (region_q)
      REGION_RAM:  memory_read_data = ram_rd;
      REGION_VRAM: memory_read_data = vram_rd;
      REGION_IO:   memory_read_data = io_capture;
      default:     memory_read_data = 4'h0;
    endcase
  end

endmodule
